// File: rtl/pipe_stage4_collect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : stage_pkg                                                 |
// | Purpose   : Shared default parameters and the FIFO entry type used    |
// |             by the stage-3 / stage-4 outlier collection pipeline.     |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package stage_pkg;

  localparam int c_parallel_size_def = 12;
  localparam int c_para_def          = 16;
  localparam int c_depth_def         = 32;
  localparam int c_cnt_w_def         = 16;

  // One compacted outlier slot: index plus end-of-row / empty-row markers
  typedef struct packed {
    logic [c_para_def-1:0] idx;
    logic                  last;
    logic                  none;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage4_collect_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : pipe_stage4_collect_if                                    |
// | Purpose   : Beat input handshake, compacted index output stream and   |
// |             row counter of the stage-4 collector.                     |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface pipe_stage4_collect_if #(
  parameter int PARALLEL_SIZE = 12,
  parameter int PARA          = 16,
  parameter int CNT_W         = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [PARALLEL_SIZE-1:0]      in_flag;
  logic [PARALLEL_SIZE*PARA-1:0] in_idx;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [PARA-1:0]               out_idx;
  logic                          out_last;
  logic                          out_none;
  logic [CNT_W-1:0]              row_cnt;

  // Producer of beats and consumer of indices
  modport master (
    output in_valid, in_flag, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none, row_cnt
  );

  // The collector itself
  modport slave (
    input  in_valid, in_flag, in_idx, in_last, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none, row_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage4_collect_lane_prefix_compact.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : lane_prefix_compact                                       |
// | Purpose   : Exclusive prefix popcount over the lane flags: each lane's |
// |             slot offset within the beat, plus the total flag count.   |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module lane_prefix_compact #(
  parameter int LANES = 12,
  parameter int KW    = 4
) (
  input  logic [LANES-1:0]         flag,
  output logic [LANES-1:0][KW-1:0] offset,
  output logic [KW-1:0]            k
);

  // Running count of flagged lanes below each lane, lowest lane first
  always_comb begin
    logic [KW-1:0] w_acc;
    w_acc  = '0;
    offset = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i] = w_acc;
      w_acc     = w_acc + KW'(flag[i]);
    end
    k = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage4_collect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : pipe_stage4_collect                                       |
// | Purpose   : Compacts flagged lane indices of each beat into a FIFO,   |
// |             drains one per cycle, marks row ends / empty rows and     |
// |             keeps a saturating per-row outlier count.                 |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pipe_stage4_collect
  import stage_pkg::*;
#(
  parameter int PARALLEL_SIZE = c_parallel_size_def,
  parameter int PARA          = c_para_def,
  parameter int DEPTH         = c_depth_def,
  parameter int CNT_W         = c_cnt_w_def
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_stage4_collect_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = $clog2(PARALLEL_SIZE + 1);

  entry_t                           r_mem [DEPTH];
  logic   [AW-1:0]                  r_wr_ptr;
  logic   [AW-1:0]                  r_rd_ptr;
  logic   [AW:0]                    r_count;
  logic   [CNT_W-1:0]               r_row_cnt;
  entry_t                           r_hold;

  logic   [PARALLEL_SIZE-1:0][KW-1:0] w_offset;
  logic   [KW-1:0]                  w_k;
  logic                             w_accept;
  logic                             w_none_beat;
  logic   [KW-1:0]                  w_push_n;
  logic                             w_pop;
  entry_t                           w_head;
  entry_t                           w_out;
  logic   [CNT_W:0]                 w_row_sum;
  logic   [CNT_W-1:0]               w_row_next;

  lane_prefix_compact #(
    .LANES (PARALLEL_SIZE),
    .KW    (KW)
  ) u_prefix (
    .flag   (bus.in_flag),
    .offset (w_offset),
    .k      (w_k)
  );

  // Admission depends on registered occupancy only, so a full beat always fits
  assign bus.in_ready = (r_count <= (AW+1)'(DEPTH - PARALLEL_SIZE));
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_none_beat  = bus.in_last && (w_k == '0);
  assign w_push_n     = !w_accept  ? '0 :
                        w_none_beat ? KW'(1) : w_k;

  // First-word-fall-through from storage; when empty, show the last popped entry
  assign bus.out_valid = (r_count != '0);
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_out         = bus.out_valid ? w_head : r_hold;
  assign bus.out_idx   = w_out.idx;
  assign bus.out_last  = w_out.last;
  assign bus.out_none  = w_out.none;

  // Saturating add of this beat's outliers onto the running row count
  assign w_row_sum  = {1'b0, r_row_cnt} + (CNT_W+1)'(w_k);
  assign w_row_next = w_row_sum[CNT_W] ? '1 : w_row_sum[CNT_W-1:0];
  assign bus.row_cnt = r_row_cnt;

  // Storage write: flagged lanes land in consecutive slots, lowest lane first
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (w_none_beat) begin
        r_mem[r_wr_ptr] <= '{idx: '0, last: 1'b1, none: 1'b1};
      end
      for (int i = 0; i < PARALLEL_SIZE; i++) begin
        if (bus.in_flag[i]) begin
          r_mem[r_wr_ptr + AW'(w_offset[i])] <= '{
            idx:  bus.in_idx[i*PARA +: PARA],
            last: bus.in_last && (w_offset[i] == (w_k - KW'(1))),
            none: 1'b0
          };
        end
      end
    end
  end

  // Pointers, occupancy and the held output entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_count  <= r_count + (AW+1)'(w_push_n) - (AW+1)'(w_pop);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_hold   <= w_head;
      end
    end
  end

  // Row outlier count: accumulate on ordinary beats, clear on the row's last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
    end else if (w_accept) begin
      r_row_cnt <= bus.in_last ? '0 : w_row_next;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= (AW+1)'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage4_collect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_pipe_stage4_collect                                    |
// | Purpose   : Self-checking bench: table of beats, scoreboard of        |
// |             expected entries, and multi-cycle corner sequences.       |
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pipe_stage4_collect;
  import stage_pkg::*;

  localparam int PS    = 12;
  localparam int PARA  = 16;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage4_collect_if #(.PARALLEL_SIZE(PS), .PARA(PARA), .CNT_W(16)) bus ();
  pipe_stage4_collect_if #(.PARALLEL_SIZE(PS), .PARA(PARA), .CNT_W(4))  bus4 ();

  pipe_stage4_collect #(.PARALLEL_SIZE(PS), .PARA(PARA), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_stage4_collect #(.PARALLEL_SIZE(PS), .PARA(PARA), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    logic [PS-1:0]      flag;
    logic [PS*PARA-1:0] idx;
    logic               last;
    int                 exp_row;
  } vec_t;

  vec_t   vt [6];
  entry_t q [$];
  int     checks = 0;
  int     errors = 0;
  int     m_row  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each handshaken entry, and stability while stalled
  logic [17:0] prev;
  logic        prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_hold", 32'({bus.out_idx, bus.out_last, bus.out_none}), 32'(prev));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got idx 0x%0h with empty scoreboard, required no output", bus.out_idx);
        end else begin
          entry_t e;
          e = q.pop_front();
          check("out_entry", 32'({bus.out_idx, bus.out_last, bus.out_none}), 32'(e));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = {bus.out_idx, bus.out_last, bus.out_none};
    end
  end

  task automatic send(input logic [PS-1:0] flag, input logic [PS*PARA-1:0] idx, input logic last);
    int n;
    int k;
    int waited;
    bus.in_valid = 1'b1;
    bus.in_flag  = flag;
    bus.in_idx   = idx;
    bus.in_last  = last;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready 0, required 1 within 100 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    k = $countones(flag);
    n = 0;
    for (int i = 0; i < PS; i++) begin
      if (flag[i]) begin
        n++;
        q.push_back('{idx: idx[i*PARA +: PARA], last: (last && n == k), none: 1'b0});
      end
    end
    if (last && k == 0) q.push_back('{idx: '0, last: 1'b1, none: 1'b1});
    if (last) m_row = 0;
    else      m_row = (m_row + k > 65535) ? 65535 : m_row + k;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("row_cnt_model", 32'(bus.row_cnt), 32'(m_row));
  endtask

  task automatic send4(input logic [PS-1:0] flag, input logic last, input int exp_row);
    int waited;
    bus4.in_valid = 1'b1;
    bus4.in_flag  = flag;
    bus4.in_last  = last;
    waited = 0;
    @(negedge clk);
    while (!bus4.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus4.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready4_timeout: got in_ready 0, required 1 within 100 cycles");
      bus4.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    check("row_cnt_w4", 32'(bus4.row_cnt), 32'(exp_row));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0 || bus.out_valid) begin
      errors++;
      $display("FAIL drain: %0d entries pending, out_valid %0b, required 0 and 0", q.size(), bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PS*PARA-1:0] lanes(input int base);
    logic [PS*PARA-1:0] r;
    for (int i = 0; i < PS; i++) r[i*PARA +: PARA] = PARA'(base + i);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PS*PARA-1:0] v0;
    bus.in_valid  = 1'b0;
    bus.in_flag   = '0;
    bus.in_idx    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_flag   = '0;
    bus4.in_idx    = '0;
    bus4.in_last   = 1'b0;
    bus4.out_ready = 1'b1;

    // Beat table: idx lanes, flags, last, and row count expected after the beat
    v0 = lanes(16'h0300);
    v0[0*PARA +: PARA] = 16'd7;
    v0[2*PARA +: PARA] = 16'd9;
    vt[0] = '{flag: 12'h005, idx: v0,               last: 1'b1, exp_row: 0};
    vt[1] = '{flag: 12'h000, idx: lanes(16'h0400), last: 1'b1, exp_row: 0};
    vt[2] = '{flag: 12'h0A0, idx: lanes(16'h0500), last: 1'b0, exp_row: 2};
    vt[3] = '{flag: 12'h800, idx: lanes(16'h0600), last: 1'b0, exp_row: 3};
    vt[4] = '{flag: 12'h000, idx: lanes(16'h0700), last: 1'b0, exp_row: 3};
    vt[5] = '{flag: 12'h003, idx: lanes(16'h0800), last: 1'b1, exp_row: 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_idx",   32'(bus.out_idx),   32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_none",  32'(bus.out_none),  32'd0);
    check("rst_row_cnt",   32'(bus.row_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Table-driven beats with the consumer always ready
    bus.out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send(vt[v].flag, vt[v].idx, vt[v].last);
      check("tbl_row_cnt", 32'(bus.row_cnt), 32'(vt[v].exp_row));
    end
    wait_drain();
    check("empty_holds_last_idx",  32'(bus.out_idx),  32'h0801);
    check("empty_holds_last_last", 32'(bus.out_last), 32'd1);

    // Fill with two full beats under back-pressure, then drain across the wrap
    bus.out_ready = 1'b0;
    send({PS{1'b1}}, lanes(16'h0100), 1'b0);
    send({PS{1'b1}}, lanes(16'h0200), 1'b0);
    check("full_count",    32'(dut.r_count),  32'd24);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      check("in_ready_recover", 32'(bus.in_ready), (c < 4) ? 32'd0 : 32'd1);
    end
    wait_drain();

    // Simultaneous push of three and pop of one at occupancy five
    bus.out_ready = 1'b0;
    send(12'h01F, lanes(16'h0A00), 1'b0);
    check("pp_count_before", 32'(dut.r_count), 32'd5);
    bus.out_ready = 1'b1;
    send(12'h007, lanes(16'h0B00), 1'b0);
    check("pp_count_after", 32'(dut.r_count), 32'd7);
    wait_drain();

    // Reset mid-row with ten entries queued
    bus.out_ready = 1'b0;
    send(12'h3FF, lanes(16'h0C00), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst_row_cnt",   32'(bus.row_cnt),   32'd0);
    q.delete();
    m_row = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(12'h0F0, lanes(16'h0D00), 1'b1);
    wait_drain();

    // Narrow counter saturates within one row and clears at the row end
    send4({PS{1'b1}}, 1'b0, 12);
    send4({PS{1'b1}}, 1'b0, 15);
    send4({PS{1'b1}}, 1'b0, 15);
    send4(12'h000,    1'b1, 0);

    repeat (60) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
